// File: rtl/door_pkg.sv
// Shared state encoding for the door motor controller.
package door_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_FAULT   = 3'd4
    } door_state_e;

    function automatic logic is_travel(door_state_e s);
        return (s == ST_OPENING) || (s == ST_CLOSING);
    endfunction

endpackage

// File: rtl/door_timer.sv
// Loadable saturating counter; counts toward TERMINAL and flags the edge on which it gets there.
module door_timer #(
    parameter int               WIDTH    = 4,
    parameter bit               COUNT_UP = 1'b1,
    parameter logic [WIDTH-1:0] TERMINAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    output logic             done
);

    localparam logic [WIDTH-1:0] NEAR = COUNT_UP ? TERMINAL - WIDTH'(1) : TERMINAL + WIDTH'(1);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (enable && (count_q != TERMINAL)) begin
            count_q <= COUNT_UP ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    // done means "terminal is reached on the coming edge", so the FSM leaves exactly on time
    assign done = (count_q == TERMINAL) || (enable && (count_q == NEAR));

endmodule

// File: rtl/door_motor_ctrl.sv
// Door motor controller: drives open/close motor from door_action and limit sensors.
// Define DOOR_OBSTRUCT_EN to make the obstruct sensor reverse closing and extend the open hold.
module door_motor_ctrl
    import door_pkg::*;
#(
    parameter int TRAVEL_TIMEOUT = 1000,
    parameter int HOLD_CYCLES    = 500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               door_action,
    input  logic               limit_open,
    input  logic               limit_closed,
    input  logic               obstruct,
    input  logic               fault_clr,
    output logic               motor_open,
    output logic               motor_close,
    output logic [STATE_W-1:0] door_state,
    output logic               fault
);

    localparam int TRAVEL_W = $clog2(TRAVEL_TIMEOUT + 1);
    localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);

    door_state_e state_q, state_d;
    logic        reopen, both_limits;
    logic        travel_load, travel_en, travel_done;
    logic        hold_load, hold_en, hold_done;
    logic        motor_open_d, motor_close_d, fault_d;

`ifdef DOOR_OBSTRUCT_EN
    assign reopen = door_action | obstruct;
`else
    logic obstruct_ignored;
    assign obstruct_ignored = obstruct & 1'b0;
    assign reopen = door_action | obstruct_ignored;
`endif

    assign both_limits = limit_open & limit_closed;

    // Travel counter restarts on every entry to a travel state, reversals included.
    assign travel_load = is_travel(state_d) && (state_d != state_q);
    assign travel_en   = is_travel(state_q);
    assign hold_load   = ((state_d == ST_OPEN) && (state_q != ST_OPEN)) ||
                         ((state_q == ST_OPEN) && reopen);
    assign hold_en     = (state_q == ST_OPEN) && !reopen;

    door_timer #(
        .WIDTH   (TRAVEL_W),
        .COUNT_UP(1'b1),
        .TERMINAL(TRAVEL_W'(TRAVEL_TIMEOUT))
    ) u_travel (
        .clk     (clk),
        .rst     (rst),
        .load    (travel_load),
        .load_val('0),
        .enable  (travel_en),
        .done    (travel_done)
    );

    door_timer #(
        .WIDTH   (HOLD_W),
        .COUNT_UP(1'b0),
        .TERMINAL('0)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (hold_load),
        .load_val(HOLD_W'(HOLD_CYCLES)),
        .enable  (hold_en),
        .done    (hold_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLOSED;
            motor_open  <= 1'b0;
            motor_close <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            motor_open  <= motor_open_d;
            motor_close <= motor_close_d;
            fault       <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLOSED: begin
                if (both_limits)      state_d = ST_FAULT;
                else if (door_action) state_d = ST_OPENING;
            end
            ST_OPENING: begin
                if (both_limits)      state_d = ST_FAULT;
                else if (limit_open)  state_d = ST_OPEN;
                else if (travel_done) state_d = ST_FAULT;
            end
            ST_OPEN: begin
                if (both_limits)                state_d = ST_FAULT;
                else if (!reopen && hold_done)  state_d = ST_CLOSING;
            end
            ST_CLOSING: begin
                if (both_limits)       state_d = ST_FAULT;
                else if (reopen)       state_d = ST_OPENING;
                else if (limit_closed) state_d = ST_CLOSED;
                else if (travel_done)  state_d = ST_FAULT;
            end
            ST_FAULT: begin
                if (fault_clr)
                    state_d = (limit_closed && !limit_open) ? ST_CLOSED : ST_CLOSING;
            end
            default: state_d = ST_FAULT;
        endcase
    end

    // Outputs decode the next state so they register on the same edge as the state.
    always_comb begin
        motor_open_d  = (state_d == ST_OPENING);
        motor_close_d = (state_d == ST_CLOSING);
        fault_d       = (state_d == ST_FAULT);
    end

    assign door_state = state_q;

endmodule

// File: tb/tb_door_motor_ctrl.sv
// Self-checking bench for door_motor_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_door_motor_ctrl;

    localparam int TT = 8;
    localparam int HC = 4;

    localparam int M_CLOSED  = 0;
    localparam int M_OPENING = 1;
    localparam int M_OPEN    = 2;
    localparam int M_CLOSING = 3;
    localparam int M_FAULT   = 4;

`ifdef DOOR_OBSTRUCT_EN
    localparam bit OBS_EN = 1'b1;
`else
    localparam bit OBS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       door_action, limit_open, limit_closed, obstruct, fault_clr;
    logic       motor_open, motor_close, fault;
    logic [2:0] door_state;

    int total = 0;
    int bad   = 0;

    int m_state, m_elapsed, m_hold_left;
    logic [5:0] exp_q[$];

    door_motor_ctrl #(
        .TRAVEL_TIMEOUT(TT),
        .HOLD_CYCLES   (HC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .door_action (door_action),
        .limit_open  (limit_open),
        .limit_closed(limit_closed),
        .obstruct    (obstruct),
        .fault_clr   (fault_clr),
        .motor_open  (motor_open),
        .motor_close (motor_close),
        .door_state  (door_state),
        .fault       (fault)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- behavioural reference model ----------------
    function automatic logic [5:0] model_outputs();
        logic [2:0] s;
        s = m_state[2:0];
        return {s, m_state == M_OPENING, m_state == M_CLOSING, m_state == M_FAULT};
    endfunction

    function automatic logic [5:0] dut_outputs();
        return {door_state, motor_open, motor_close, fault};
    endfunction

    task automatic model_reset();
        m_state     = M_CLOSED;
        m_elapsed   = 0;
        m_hold_left = 0;
    endtask

    task automatic model_edge();
        bit both   = limit_open && limit_closed;
        bit reopen = door_action || (OBS_EN && obstruct);
        case (m_state)
            M_CLOSED: begin
                if (both) m_state = M_FAULT;
                else if (door_action) begin m_state = M_OPENING; m_elapsed = 0; end
            end
            M_OPENING: begin
                if (both) m_state = M_FAULT;
                else if (limit_open) begin m_state = M_OPEN; m_hold_left = HC; end
                else begin
                    m_elapsed++;
                    if (m_elapsed == TT) m_state = M_FAULT;
                end
            end
            M_OPEN: begin
                if (both) m_state = M_FAULT;
                else if (reopen) m_hold_left = HC;
                else begin
                    m_hold_left--;
                    if (m_hold_left == 0) begin m_state = M_CLOSING; m_elapsed = 0; end
                end
            end
            M_CLOSING: begin
                if (both) m_state = M_FAULT;
                else if (reopen) begin m_state = M_OPENING; m_elapsed = 0; end
                else if (limit_closed) m_state = M_CLOSED;
                else begin
                    m_elapsed++;
                    if (m_elapsed == TT) m_state = M_FAULT;
                end
            end
            default: begin
                if (fault_clr) begin
                    if (limit_closed && !limit_open) m_state = M_CLOSED;
                    else begin m_state = M_CLOSING; m_elapsed = 0; end
                end
            end
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic da, input logic lo, input logic lc, input logic ob, input logic fc);
        door_action  = da;
        limit_open   = lo;
        limit_closed = lc;
        obstruct     = ob;
        fault_clr    = fc;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic goto_closing();
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        repeat (HC) step(0, 1, 0, 0, 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        door_action = 0; limit_open = 0; limit_closed = 0; obstruct = 0; fault_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (dut_outputs() !== 6'b000_000) begin
            bad++; $display("FAIL reset_state: got=%b exp=%b", dut_outputs(), 6'b000_000);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0, 0);
            total++;
            if (door_state !== 3'd0) begin
                bad++; $display("FAIL idle_closed: got=%0d exp=0", door_state);
            end
        end
    endtask

    task automatic test_open();
        step(1, 0, 1, 0, 0);
        total++;
        if (dut_outputs() !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL open_request: got=%b exp=%b", dut_outputs(), {3'd1, 3'b100});
        end
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        total++;
        if (dut_outputs() !== {3'd2, 3'b000}) begin
            bad++; $display("FAIL reach_open: got=%b exp=%b", dut_outputs(), {3'd2, 3'b000});
        end
    endtask

    task automatic test_hold();
        for (int k = 1; k <= HC; k++) begin
            logic [5:0] exp_v;
            step(0, 1, 0, 0, 0);
            exp_v = (k < HC) ? {3'd2, 3'b000} : {3'd3, 3'b010};
            total++;
            if (dut_outputs() !== exp_v) begin
                bad++; $display("FAIL hold_cycle%0d: got=%b exp=%b", k, dut_outputs(), exp_v);
            end
        end
        step(0, 0, 1, 0, 0);
        total++;
        if (dut_outputs() !== {3'd0, 3'b000}) begin
            bad++; $display("FAIL close_done: got=%b exp=%b", dut_outputs(), {3'd0, 3'b000});
        end
    endtask

    task automatic test_reversal();
        goto_closing();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        total++;
        if (dut_outputs() !== {3'd1, 3'b100}) begin
            bad++; $display("FAIL reversal: got=%b exp=%b", dut_outputs(), {3'd1, 3'b100});
        end
        // a fresh travel count means the timeout lands a full TT edges after the reversal
        for (int k = 1; k <= TT; k++) begin
            logic [2:0] exp_s;
            step(0, 0, 0, 0, 0);
            exp_s = (k < TT) ? 3'd1 : 3'd4;
            total++;
            if (door_state !== exp_s) begin
                bad++; $display("FAIL reversal_travel%0d: got=%0d exp=%0d", k, door_state, exp_s);
            end
        end
        step(0, 0, 1, 0, 1);
        total++;
        if (door_state !== 3'd0) begin
            bad++; $display("FAIL clr_to_closed: got=%0d exp=0", door_state);
        end
    endtask

    task automatic test_timeout();
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= TT; k++) step(0, 0, 0, 0, 0);
        total++;
        if (dut_outputs() !== {3'd4, 3'b001}) begin
            bad++; $display("FAIL open_timeout: got=%b exp=%b", dut_outputs(), {3'd4, 3'b001});
        end
        step(0, 0, 1, 0, 0);
        total++;
        if (door_state !== 3'd4) begin
            bad++; $display("FAIL fault_holds: got=%0d exp=4", door_state);
        end
        step(0, 0, 0, 0, 1);
        total++;
        if (dut_outputs() !== {3'd3, 3'b010}) begin
            bad++; $display("FAIL clr_to_closing: got=%b exp=%b", dut_outputs(), {3'd3, 3'b010});
        end
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        total++;
        if (door_state !== 3'd0) begin
            bad++; $display("FAIL clr_ignored_closed: got=%0d exp=0", door_state);
        end
    endtask

    task automatic test_both_limits();
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        total++;
        if (dut_outputs() !== {3'd4, 3'b001}) begin
            bad++; $display("FAIL both_in_open: got=%b exp=%b", dut_outputs(), {3'd4, 3'b001});
        end
        step(0, 0, 1, 0, 1);
        step(1, 1, 1, 0, 0);
        total++;
        if (door_state !== 3'd4) begin
            bad++; $display("FAIL both_in_closed: got=%0d exp=4", door_state);
        end
        step(0, 0, 1, 0, 1);
    endtask

    task automatic test_async_reset();
        goto_closing();
        step(0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({door_state, motor_close, motor_open, fault} !== 6'b000_000) begin
            bad++; $display("FAIL async_reset: got=%b exp=%b",
                            {door_state, motor_close, motor_open, fault}, 6'b000_000);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1, 0, 0);
        total++;
        if (door_state !== 3'd0) begin
            bad++; $display("FAIL after_reset: got=%0d exp=0", door_state);
        end
    endtask

    task automatic test_obstruct();
        logic [2:0] exp_s;
        goto_closing();
        step(0, 0, 0, 1, 0);
        exp_s = OBS_EN ? 3'd1 : 3'd3;
        total++;
        if (door_state !== exp_s) begin
            bad++; $display("FAIL obstruct_closing: got=%0d exp=%0d", door_state, exp_s);
        end
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic da, lo, lc, ob, fc;
            logic [5:0] exp_v;
            da = ($urandom_range(0, 99) < 30);
            lo = ($urandom_range(0, 99) < 15);
            lc = ($urandom_range(0, 99) < 15);
            ob = ($urandom_range(0, 99) < 10);
            fc = ($urandom_range(0, 99) < 20);
            step(da, lo, lc, ob, fc);
            exp_q.push_back(model_outputs());
            exp_v = exp_q.pop_front();
            total++;
            if (dut_outputs() !== exp_v) begin
                bad++; $display("FAIL random_%0d: got=%b exp=%b", i, dut_outputs(), exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_open();
        test_hold();
        test_reversal();
        test_timeout();
        test_both_limits();
        test_async_reset();
        test_obstruct();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/door_motor_ctrl.md
DOOR_MOTOR_CTRL -- requirements
Module: door_motor_ctrl

Interface
REQ-001 Parameter TRAVEL_TIMEOUT, default 1000: maximum cycles allowed in OPENING or CLOSING before a fault.
REQ-002 Parameter HOLD_CYCLES, default 500: cycles the door stays OPEN after door_action deasserts.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 door_action  input  1  open request from the upstream door FSM; level, 1 = open.
REQ-006 limit_open  input  1  door fully open sensor.
REQ-007 limit_closed  input  1  door fully closed sensor.
REQ-008 obstruct  input  1  obstruction sensor; used only under DOOR_OBSTRUCT_EN.
REQ-009 fault_clr  input  1  single-cycle fault acknowledge.
REQ-010 motor_open  output  1  drive motor in the open direction.
REQ-011 motor_close  output  1  drive motor in the close direction.
REQ-012 door_state  output  3  current state encoding.
REQ-013 fault  output  1  high while in FAULT.

Function
REQ-014 States SHALL be CLOSED=0, OPENING=1, OPEN=2, CLOSING=3, FAULT=4; other codes SHALL go to FAULT on the next edge.
REQ-015 All outputs SHALL be registered and SHALL update on the same edge as the state: motor_open=1 only in OPENING, motor_close=1 only in CLOSING, both never 1 together.
REQ-016 CLOSED: door_action=1 -> OPENING on the next edge; otherwise hold.
REQ-017 OPENING priority: both limits=1 -> FAULT; else limit_open=1 -> OPEN; else TRAVEL_TIMEOUT cycles elapsed in the state -> FAULT.
REQ-018 OPEN: hold counter SHALL load HOLD_CYCLES on entry and on every cycle door_action=1; it decrements while door_action=0; reaching 0 -> CLOSING.
REQ-019 CLOSING priority: both limits=1 -> FAULT; else door_action=1 -> OPENING (reversal); else limit_closed=1 -> CLOSED; else timeout -> FAULT.
REQ-020 Travel counter SHALL clear on every entry to OPENING or CLOSING, including a reversal, and saturate at TRAVEL_TIMEOUT; width SHALL be $clog2(TRAVEL_TIMEOUT+1).
REQ-021 Both limits=1 in CLOSED or OPEN SHALL -> FAULT.
REQ-022 FAULT: motors off, fault=1; fault_clr=1 -> CLOSED if limit_closed=1 and limit_open=0, else CLOSING; fault_clr SHALL be ignored in other states.
REQ-023 door_state SHALL equal the state register every cycle.

Reset
REQ-024 rst=1 SHALL immediately force state CLOSED, motor_open=0, motor_close=0, fault=0, door_state=0, and clear both counters, including mid-travel.
REQ-025 After rst falls, the first transition SHALL occur on the first rising edge at which the REQ-016 condition holds.

Configuration
REQ-026 Macro DOOR_OBSTRUCT_EN defined: obstruct=1 in CLOSING SHALL -> OPENING, same priority as door_action, and obstruct=1 in OPEN SHALL reload the hold counter.
REQ-027 Macro DOOR_OBSTRUCT_EN undefined: the obstruct port SHALL remain present and be ignored.

Structure
REQ-028 Package door_pkg SHALL hold the state typedef, its encodings, and the 3-bit state width constant.
REQ-029 Sub-module door_timer, a loadable saturating counter with load, enable and done, SHALL be instantiated twice: travel and hold.

Verification
REQ-030 Reset, then door_action=1 for 1 cycle -> OPENING, motor_open=1 next edge; limit_open=1 -> OPEN, motor_open=0.
REQ-031 HOLD_CYCLES=4, OPEN with door_action=0 -> CLOSING exactly 4 edges later; limit_closed=1 -> CLOSED.
REQ-032 CLOSING, door_action=1 on cycle 3 -> OPENING next edge, travel counter restarts at 0.
REQ-033 TRAVEL_TIMEOUT=8, OPENING with no limit -> FAULT after 8 cycles, motors off; fault_clr with limit_closed=1 -> CLOSED.
REQ-034 limit_open=limit_closed=1 in OPEN -> FAULT next edge; rst asserted mid-CLOSING -> CLOSED and motor_close=0 without waiting for a clock edge.
REQ-035 With DOOR_OBSTRUCT_EN, obstruct=1 in CLOSING -> OPENING; without the macro, same stimulus -> stays CLOSING.
